// File: rtl/tow_match_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tow_match_ctrl_if
// Description : Bus between the Tug of War match controller and its
//               surroundings (key-press pulses, score-tracker flags, tracker
//               controls and match status).
//               slave  : seen by the controller
//               master : seen by whatever drives the keys / trackers
// Ports       : start, press_l, press_r, win_l, win_r  -> controller
//               inc_l, inc_r, freeze[1:0], round_clr,
//               score_l/score_r[CW-1:0], match_winner[1:0] <- controller
// Revision    : 1.0 - initial release
// ============================================================================
interface tow_match_ctrl_if #(
  parameter int CW = 3
);
  logic          start;
  logic          press_l;
  logic          press_r;
  logic          win_l;
  logic          win_r;
  logic          inc_l;
  logic          inc_r;
  logic [1:0]    freeze;
  logic          round_clr;
  logic [CW-1:0] score_l;
  logic [CW-1:0] score_r;
  logic [1:0]    match_winner;

  modport slave (
    input  start, press_l, press_r, win_l, win_r,
    output inc_l, inc_r, freeze, round_clr, score_l, score_r, match_winner
  );

  modport master (
    output start, press_l, press_r, win_l, win_r,
    input  inc_l, inc_r, freeze, round_clr, score_l, score_r, match_winner
  );
endinterface
`default_nettype wire

// File: rtl/tow_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tow_match_ctrl
// Description : Tug of War match controller. Arbitrates the two players'
//               press pulses into single increment pulses for the score
//               trackers, freezes the trackers between rounds, counts rounds
//               won and declares the match winner.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous active-low reset
//               bus    - tow_match_ctrl_if.slave (key/tracker/status signals)
// Revision    : 1.0 - initial release
// ============================================================================
module tow_match_ctrl #(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int CW            = 3,
  parameter int HOLD_CYCLES   = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  tow_match_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam int            c_HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   c_RTW       = CW'(ROUNDS_TO_WIN);

  state_t          r_state,   w_state;
  logic [CW-1:0]   r_score_l, w_score_l;
  logic [CW-1:0]   r_score_r, w_score_r;
  logic [1:0]      r_winner,  w_winner;
  logic            r_round_clr, w_round_clr;
  logic [c_HW-1:0] r_hold_cnt, w_hold_cnt;
  logic            w_inc_l, w_inc_r;
  logic [1:0]      w_freeze;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_winner    <= 2'b00;
      r_round_clr <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state;
      r_score_l   <= w_score_l;
      r_score_r   <= w_score_r;
      r_winner    <= w_winner;
      r_round_clr <= w_round_clr;
      r_hold_cnt  <= w_hold_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_score_l   = r_score_l;
    w_score_r   = r_score_r;
    w_winner    = r_winner;
    w_round_clr = 1'b0;
    w_hold_cnt  = r_hold_cnt;
    w_inc_l     = 1'b0;
    w_inc_r     = 1'b0;
    w_freeze    = 2'b11;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          w_state     = S_PLAY;
          w_score_l   = '0;
          w_score_r   = '0;
          w_winner    = 2'b00;
          w_round_clr = 1'b1;
        end
      end

      S_PLAY: begin
        w_freeze = 2'b00;
        // Trackers are being cleared this cycle, so no increment may reach them.
        w_inc_l  = ~r_round_clr & bus.press_l & ~bus.press_r;
        w_inc_r  = ~r_round_clr & bus.press_r & ~bus.press_l;
        if (bus.win_l | bus.win_r) begin
          // Both flags at once is a draw: hold, then replay with scores untouched.
          w_state    = S_HOLD;
          w_hold_cnt = c_HOLD_LOAD;
          if (bus.win_l & ~bus.win_r & (r_score_l != c_RTW))
            w_score_l = r_score_l + CW'(1);
          if (bus.win_r & ~bus.win_l & (r_score_r != c_RTW))
            w_score_r = r_score_r + CW'(1);
        end
      end

      S_HOLD: begin
        if (r_hold_cnt == '0) begin
          if (r_score_l == c_RTW) begin
            w_state  = S_OVER;
            w_winner = 2'b01;
          end else if (r_score_r == c_RTW) begin
            w_state  = S_OVER;
            w_winner = 2'b10;
          end else begin
            w_state     = S_PLAY;
            w_round_clr = 1'b1;
          end
        end else begin
          w_hold_cnt = r_hold_cnt - c_HW'(1);
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign bus.inc_l        = w_inc_l;
  assign bus.inc_r        = w_inc_r;
  assign bus.freeze       = w_freeze;
  assign bus.round_clr    = r_round_clr;
  assign bus.score_l      = r_score_l;
  assign bus.score_r      = r_score_r;
  assign bus.match_winner = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_tow_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tow_match_ctrl
// Description : Self-checking bench for tow_match_ctrl. A behavioural match
//               model tracks mode, scores and remaining hold cycles; outputs
//               are compared against it every falling edge. Directed
//               scenarios with literal expectations come first, then a
//               randomized run with occasional mid-cycle resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tow_match_ctrl;
  localparam int R  = 3;
  localparam int CW = 3;
  localparam int H  = 4;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_HOLD = 2;
  localparam int M_OVER = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  tow_match_ctrl_if #(.CW(CW)) bus();

  tow_match_ctrl #(.ROUNDS_TO_WIN(R), .CW(CW), .HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode = M_IDLE;
  int m_sl   = 0;
  int m_sr   = 0;
  int m_win  = 0;
  int m_left = 0;   // hold cycles still to spend, including the current one
  bit m_clr  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_win = 0; m_left = 0; m_clr = 1'b0;
    end else begin
      bit clr_next;
      clr_next = 1'b0;
      case (m_mode)
        M_IDLE, M_OVER: if (bus.start) begin
          m_mode = M_PLAY; m_sl = 0; m_sr = 0; m_win = 0; clr_next = 1'b1;
        end
        M_PLAY: if (bus.win_l || bus.win_r) begin
          if (bus.win_l && !bus.win_r) m_sl = (m_sl < R) ? m_sl + 1 : R;
          if (bus.win_r && !bus.win_l) m_sr = (m_sr < R) ? m_sr + 1 : R;
          m_mode = M_HOLD;
          m_left = H;
        end
        M_HOLD: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_sl == R)      begin m_mode = M_OVER; m_win = 1; end
            else if (m_sr == R) begin m_mode = M_OVER; m_win = 2; end
            else                begin m_mode = M_PLAY; clr_next = 1'b1; end
          end
        end
        default: ;
      endcase
      m_clr = clr_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit play;
    play = (m_mode == M_PLAY);
    chk("inc_l",  int'(bus.inc_l),  int'(play && !m_clr && bus.press_l && !bus.press_r));
    chk("inc_r",  int'(bus.inc_r),  int'(play && !m_clr && bus.press_r && !bus.press_l));
    chk("freeze", int'(bus.freeze), play ? 0 : 3);
    chk("round_clr", int'(bus.round_clr), int'(m_clr));
    chk("score_l", int'(bus.score_l), m_sl);
    chk("score_r", int'(bus.score_r), m_sr);
    chk("match_winner", int'(bus.match_winner), m_win);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 0; bus.press_l = 0; bus.press_r = 0; bus.win_l = 0; bus.win_r = 0;
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_freeze", int'(bus.freeze), 3);
    chk("rst_score_l", int'(bus.score_l), 0);
    chk("rst_winner", int'(bus.match_winner), 0);
    chk("rst_round_clr", int'(bus.round_clr), 0);

    // start, then first PLAY cycle carries round_clr and suppresses inc
    step(); bus.start = 1;
    @(negedge clk); chk("idle_freeze", int'(bus.freeze), 3);
    step(); bus.start = 0; bus.press_l = 1;
    @(negedge clk);
    chk("first_clr", int'(bus.round_clr), 1);
    chk("first_inc_l", int'(bus.inc_l), 0);
    chk("play_freeze", int'(bus.freeze), 0);
    step();
    @(negedge clk); chk("inc_l", int'(bus.inc_l), 1);
    step(); bus.press_l = 0;
    @(negedge clk); chk("inc_l_off", int'(bus.inc_l), 0);

    // simultaneous press cancels; right alone increments
    step(); bus.press_l = 1; bus.press_r = 1;
    @(negedge clk);
    chk("both_inc_l", int'(bus.inc_l), 0);
    chk("both_inc_r", int'(bus.inc_r), 0);
    step(); bus.press_l = 0;
    @(negedge clk); chk("inc_r", int'(bus.inc_r), 1);
    step(); bus.press_r = 0;

    // right wins a round: 4 frozen cycles then a cleared new round
    bus.win_r = 1;
    for (int i = 0; i < H; i++) begin
      step(); bus.win_r = 0;
      @(negedge clk);
      chk("hold_freeze", int'(bus.freeze), 3);
      chk("hold_score_r", int'(bus.score_r), 1);
    end
    step();
    @(negedge clk);
    chk("replay_clr", int'(bus.round_clr), 1);
    chk("replay_freeze", int'(bus.freeze), 0);

    // draw: hold, scores unchanged, round replayed
    step(); bus.win_l = 1; bus.win_r = 1;
    step(); bus.win_l = 0; bus.win_r = 0;
    @(negedge clk);
    chk("draw_freeze", int'(bus.freeze), 3);
    chk("draw_score_l", int'(bus.score_l), 0);
    chk("draw_score_r", int'(bus.score_r), 1);
    repeat (H) step();
    @(negedge clk); chk("draw_replay_clr", int'(bus.round_clr), 1);

    // left takes three rounds and the match
    for (int r = 0; r < R; r++) begin
      step(); bus.win_l = 1;
      step(); bus.win_l = 0;
      repeat (H) step();
    end
    @(negedge clk);
    chk("over_winner", int'(bus.match_winner), 1);
    chk("over_score_l", int'(bus.score_l), 3);
    chk("over_freeze", int'(bus.freeze), 3);
    step(); bus.press_l = 1;
    @(negedge clk); chk("over_inc_l", int'(bus.inc_l), 0);
    step(); bus.press_l = 0; bus.start = 1;
    step(); bus.start = 0;
    @(negedge clk);
    chk("restart_score_l", int'(bus.score_l), 0);
    chk("restart_winner", int'(bus.match_winner), 0);
    chk("restart_clr", int'(bus.round_clr), 1);

    // asynchronous reset in the middle of an increment
    step(); bus.press_l = 1;
    @(negedge clk); chk("pre_rst_inc_l", int'(bus.inc_l), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_inc_l", int'(bus.inc_l), 0);
    chk("async_freeze", int'(bus.freeze), 3);
    chk("async_score_r", int'(bus.score_r), 0);
    chk("async_clr", int'(bus.round_clr), 0);
    step(); reset = 1'b1;
    @(negedge clk);
    chk("post_rst_freeze", int'(bus.freeze), 3);
    chk("post_rst_inc_l", int'(bus.inc_l), 0);
    bus.press_l = 0;

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      step();
      if (!reset) reset = 1'b1;
      bus.start   = ($urandom % 16) == 0;
      bus.press_l = $urandom % 2;
      bus.press_r = $urandom % 2;
      bus.win_l   = ($urandom % 12) == 0;
      bus.win_r   = ($urandom % 12) == 0;
      if (($urandom % 600) == 0) reset = 1'b0;
    end
    step();
    reset = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
